// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc
//   Hazard detection and operand forwarding for the 5-stage RISC-V pipeline.
//   Handles load-use stalls (multi-cycle), multi-cycle execute waits with a
//   timeout, branch flushes, and keeps a saturating count of stalled cycles.
//
// Ports
//   clk, rst                 pipeline clock, asynchronous active-low reset
//   RegWriteE/M/W            register write enables per stage
//   ResultSrcE               E-stage instruction is a load
//   PCSrcE                   branch/jump taken in E
//   McStartE, McDoneE        multi-cycle op in E / its result valid this cycle
//   UsesRS1D, UsesRS2D       D-stage instruction reads rs1 / rs2
//   RS1D..RDW                register addresses (REG_AW bits)
//   StallF/D/E               hold PC, IF/ID, ID/EX
//   FlushD/E/M               bubble IF/ID, ID/EX, EX/MEM
//   ForwardAE/BE             E operand select: 10=M, 01=W, 00=regfile
//   McErr                    sticky multi-cycle timeout flag
//   StallCount               saturating count of cycles with StallF=1
module hazard_unit_mc #(
  parameter int unsigned REG_AW            = 5,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MC_TIMEOUT        = 64,
  parameter int unsigned PERF_W            = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE,
  input  logic              PCSrcE,
  input  logic              McStartE,
  input  logic              McDoneE,
  input  logic              UsesRS1D,
  input  logic              UsesRS2D,
  input  logic [REG_AW-1:0] RS1D,
  input  logic [REG_AW-1:0] RS2D,
  input  logic [REG_AW-1:0] RS1E,
  input  logic [REG_AW-1:0] RS2E,
  input  logic [REG_AW-1:0] RDE,
  input  logic [REG_AW-1:0] RDM,
  input  logic [REG_AW-1:0] RDW,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              McErr,
  output logic [PERF_W-1:0] StallCount
);

  // Wide enough for both LOAD_STALL_CYCLES (<=15) and MC_TIMEOUT (<=1023).
  localparam int unsigned CW = 10;

  typedef enum logic [1:0] {
    RUN,
    LD_STALL,
    MC_WAIT
  } state_t;

  state_t            state, stateNext;
  logic [CW-1:0]     cnt, cntNext;
  logic              mcErrQ, mcErrNext;
  logic [PERF_W-1:0] stallCnt;

  logic              ldHaz;
  logic              sF, sD, sE, fD, fE, fM;
  logic [1:0]        fwdA, fwdB;

  // Forwarding: M stage has priority over W; x0 is never forwarded.
  always_comb begin
    fwdA = 2'b00;
    if (RegWriteM && (RDM != '0) && (RDM == RS1E))      fwdA = 2'b10;
    else if (RegWriteW && (RDW != '0) && (RDW == RS1E)) fwdA = 2'b01;

    fwdB = 2'b00;
    if (RegWriteM && (RDM != '0) && (RDM == RS2E))      fwdB = 2'b10;
    else if (RegWriteW && (RDW != '0) && (RDW == RS2E)) fwdB = 2'b01;
  end

  // Operand-use flags suppress stalls for instructions that ignore rs1/rs2.
  always_comb begin
    ldHaz = ResultSrcE && RegWriteE && (RDE != '0) &&
            ((UsesRS1D && (RS1D == RDE)) || (UsesRS2D && (RS2D == RDE)));
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    mcErrNext = mcErrQ;
    sF = 1'b0; sD = 1'b0; sE = 1'b0;
    fD = 1'b0; fE = 1'b0; fM = 1'b0;

    unique case (state)
      RUN: begin
        if (PCSrcE) begin
          fD = 1'b1;
          fE = 1'b1;
        end else if (McStartE && !McDoneE) begin
          sF = 1'b1; sD = 1'b1; sE = 1'b1; fM = 1'b1;
          stateNext = MC_WAIT;
          cntNext   = CW'(1);
        end else if (McStartE) begin
          // Multi-cycle op finished in its first cycle: nothing to hold.
        end else if (ldHaz) begin
          sF = 1'b1; sD = 1'b1; fE = 1'b1;
          // The first bubble is inserted here; the remainder come from LD_STALL.
          if (LOAD_STALL_CYCLES > 1) begin
            stateNext = LD_STALL;
            cntNext   = CW'(LOAD_STALL_CYCLES - 1);
          end
        end
      end

      LD_STALL: begin
        sF = 1'b1; sD = 1'b1; fE = 1'b1;
        if (cnt <= CW'(1)) stateNext = RUN;
        else               cntNext   = cnt - 1'b1;
      end

      MC_WAIT: begin
        if (McDoneE) begin
          stateNext = RUN;
        end else if (cnt >= CW'(MC_TIMEOUT)) begin
          stateNext = RUN;
          mcErrNext = 1'b1;
        end else begin
          sF = 1'b1; sD = 1'b1; sE = 1'b1; fM = 1'b1;
          cntNext = cnt + 1'b1;
        end
      end

      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      cnt      <= '0;
      mcErrQ   <= 1'b0;
      stallCnt <= '0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      mcErrQ <= mcErrNext;
      if (sF && (stallCnt != '1)) stallCnt <= stallCnt + 1'b1;
    end
  end

  // Every output, combinational ones included, is held at 0 while in reset.
  always_comb begin
    StallF     = rst & sF;
    StallD     = rst & sD;
    StallE     = rst & sE;
    FlushD     = rst & fD;
    FlushE     = rst & fE;
    FlushM     = rst & fM;
    ForwardAE  = rst ? fwdA : 2'b00;
    ForwardBE  = rst ? fwdB : 2'b00;
    McErr      = rst & mcErrQ;
    StallCount = rst ? stallCnt : '0;
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc
//   Directed and randomized checks of hazard_unit_mc (LOAD_STALL_CYCLES=2,
//   MC_TIMEOUT=8, PERF_W=4) against a cycle-level reference model.
module tb_hazard_unit_mc;

  localparam int unsigned AW  = 5;
  localparam int unsigned LSC = 2;
  localparam int unsigned TO  = 8;
  localparam int unsigned PW  = 4;
  localparam int unsigned SAT = (1 << PW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE;
  logic          McStartE, McDoneE, UsesRS1D, UsesRS2D;
  logic [AW-1:0] RS1D, RS2D, RS1E, RS2E, RDE, RDM, RDW;
  logic          StallF, StallD, StallE, FlushD, FlushE, FlushM, McErr;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [PW-1:0] StallCount;

  hazard_unit_mc #(
    .REG_AW(AW), .LOAD_STALL_CYCLES(LSC), .MC_TIMEOUT(TO), .PERF_W(PW)
  ) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .McStartE(McStartE), .McDoneE(McDoneE),
    .UsesRS1D(UsesRS1D), .UsesRS2D(UsesRS2D),
    .RS1D(RS1D), .RS2D(RS2D), .RS1E(RS1E), .RS2E(RS2E),
    .RDE(RDE), .RDM(RDM), .RDW(RDW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .McErr(McErr), .StallCount(StallCount)
  );

  int nVec = 0;
  int nErr = 0;

  // Reference model state: bubbles still owed, multi-cycle wait progress.
  int unsigned mLdLeft   = 0;
  bit          mInMc     = 1'b0;
  int unsigned mMcCycles = 0;
  bit          mErr      = 1'b0;
  int unsigned mCount    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwdRef(input logic [AW-1:0] rs);
    if (RegWriteM && RDM != 0 && RDM == rs) return 2'b10;
    if (RegWriteW && RDW != 0 && RDW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ldHazRef();
    return ResultSrcE && RegWriteE && RDE != 0 &&
           ((UsesRS1D && RS1D == RDE) || (UsesRS2D && RS2D == RDE));
  endfunction

  // Let inputs settle, compare every output to the model, then advance the
  // model over the coming clock edge.
  task automatic settle();
    logic eSF, eSD, eSE, eFD, eFE, eFM;
    bit   timeoutHit;
    #1;
    {eSF, eSD, eSE, eFD, eFE, eFM} = '0;
    timeoutHit = 1'b0;
    if (!rst) begin
      mLdLeft = 0; mInMc = 1'b0; mMcCycles = 0; mErr = 1'b0; mCount = 0;
    end else if (mInMc) begin
      if (McDoneE) mInMc = 1'b0;
      else if (mMcCycles >= TO) begin
        mInMc = 1'b0;
        timeoutHit = 1'b1;
      end else begin
        {eSF, eSD, eSE, eFM} = '1;
        mMcCycles++;
      end
    end else if (mLdLeft > 0) begin
      {eSF, eSD, eFE} = '1;
      mLdLeft--;
    end else if (PCSrcE) begin
      {eFD, eFE} = '1;
    end else if (McStartE && !McDoneE) begin
      {eSF, eSD, eSE, eFM} = '1;
      mInMc = 1'b1;
      mMcCycles = 1;
    end else if (!McStartE && ldHazRef()) begin
      {eSF, eSD, eFE} = '1;
      mLdLeft = LSC - 1;
    end
    chk("StallF", 32'(StallF), 32'(eSF));
    chk("StallD", 32'(StallD), 32'(eSD));
    chk("StallE", 32'(StallE), 32'(eSE));
    chk("FlushD", 32'(FlushD), 32'(eFD));
    chk("FlushE", 32'(FlushE), 32'(eFE));
    chk("FlushM", 32'(FlushM), 32'(eFM));
    chk("ForwardAE", 32'(ForwardAE), rst ? 32'(fwdRef(RS1E)) : 32'd0);
    chk("ForwardBE", 32'(ForwardBE), rst ? 32'(fwdRef(RS2E)) : 32'd0);
    chk("McErr", 32'(McErr), 32'(mErr));
    chk("StallCount", 32'(StallCount), mCount);
    if (rst) begin
      if (timeoutHit) mErr = 1'b1;
      if (eSF && mCount < SAT) mCount++;
    end
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  task automatic idle();
    {RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE} = '0;
    {McStartE, McDoneE, UsesRS1D, UsesRS2D} = '0;
    {RS1D, RS2D, RS1E, RS2E, RDE, RDM, RDW} = '0;
  endtask

  task automatic loadX7();
    idle();
    RegWriteE = 1'b1; ResultSrcE = 1'b1; RDE = 5'd7;
    RS1D = 5'd7; UsesRS1D = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    @(negedge clk);

    // Reset state
    settle(); chk("rst_count", 32'(StallCount), 32'd0); adv();
    settle(); chk("rst_err", 32'(McErr), 32'd0); adv();
    rst = 1'b1;

    // Forwarding collision: M beats W, then W alone, then none
    RegWriteM = 1'b1; RegWriteW = 1'b1; RDM = 5'd5; RDW = 5'd5; RS1E = 5'd5;
    settle(); chk("fwd_M", 32'(ForwardAE), 32'd2); adv();
    RDM = 5'd0;
    settle(); chk("fwd_W", 32'(ForwardAE), 32'd1); adv();
    RDW = 5'd0;
    settle(); chk("fwd_none", 32'(ForwardAE), 32'd0); adv();

    // Load-use: exactly two bubbles
    loadX7();
    settle(); chk("ld_c1", 32'({StallF, StallD, FlushE}), 32'd7); adv();
    idle(); RS1D = 5'd7; UsesRS1D = 1'b1;
    settle(); chk("ld_c2", 32'({StallF, StallD, FlushE}), 32'd7); adv();
    settle(); chk("ld_c3", 32'({StallF, StallD, FlushE}), 32'd0);
    chk("ld_count", 32'(StallCount), 32'd2); adv();

    // False stalls suppressed
    loadX7(); UsesRS1D = 1'b0;
    settle(); chk("nouse", 32'(StallF), 32'd0); adv();
    loadX7(); RDE = 5'd0; RS1D = 5'd0;
    settle(); chk("rde0", 32'(StallF), 32'd0); adv();

    // Multi-cycle op finishing on cycle 5
    idle(); McStartE = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      settle(); chk("mc_hold", 32'({StallF, StallD, StallE, FlushM}), 32'hF); adv();
    end
    McDoneE = 1'b1;
    settle(); chk("mc_done", 32'({StallF, StallD, StallE, FlushM}), 32'h0); adv();
    idle();
    settle(); chk("mc_run", 32'(StallF), 32'd0); adv();

    // Timeout with a branch pulse during the wait
    idle(); McStartE = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      PCSrcE = (c == 4);
      settle(); chk("to_hold", 32'({StallF, StallE, FlushD, FlushE}), 32'hC); adv();
    end
    PCSrcE = 1'b0;
    settle(); chk("to_drop", 32'(StallF), 32'd0); adv();
    idle();
    settle(); chk("to_err", 32'(McErr), 32'd1); adv();
    settle(); chk("to_sticky", 32'(McErr), 32'd1); adv();

    // Reset in the middle of a load stall
    loadX7();
    settle(); adv();
    idle(); rst = 1'b0;
    settle();
    chk("rstmid_out", 32'({StallF, StallD, FlushE, McErr}), 32'd0);
    chk("rstmid_cnt", 32'(StallCount), 32'd0); adv();
    rst = 1'b1;
    settle(); chk("rstmid_run", 32'(StallF), 32'd0); adv();

    // Twenty stall cycles saturate the 4-bit counter
    for (int k = 0; k < 10; k++) begin
      loadX7(); settle(); adv();
      idle();   settle(); adv();
    end
    settle(); chk("saturate", 32'(StallCount), 32'd15); adv();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      int unsigned kind;
      rst        = ($urandom_range(0, 99) != 0);
      kind       = $urandom_range(0, 3);
      ResultSrcE = (kind == 1);
      McStartE   = (kind == 2);
      PCSrcE     = (kind == 3);
      McDoneE    = ($urandom_range(0, 3) == 0);
      RegWriteE  = 1'($urandom);
      RegWriteM  = 1'($urandom);
      RegWriteW  = 1'($urandom);
      UsesRS1D   = 1'($urandom);
      UsesRS2D   = 1'($urandom);
      RS1D = AW'($urandom_range(0, 3)); RS2D = AW'($urandom_range(0, 3));
      RS1E = AW'($urandom_range(0, 3)); RS2E = AW'($urandom_range(0, 3));
      RDE  = AW'($urandom_range(0, 3)); RDM  = AW'($urandom_range(0, 3));
      RDW  = AW'($urandom_range(0, 3));
      settle(); adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
